vec_product_pipe: RTL and testbench

//  Pipelined signed/unsigned dot-product engine with a registered adder tree and

---
 rtl/vec_product_pipe.sv | 164 ++++++++++++++++
 tb/tb_vec_product_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_product_pipe.sv
// vec_product_pipe
//   Pipelined dot-product engine. Each accepted beat carries one pair of
//   VEC_SIZE-element vectors; the element products are registered, reduced by
//   a registered pairwise adder tree (one level per stage), and folded into a
//   wrapping accumulator. Long reductions span several beats delimited by
//   i_first / i_last; one result is emitted per last beat.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready    input beat handshake; o_ready is combinational from i_ready
//   i_a, i_b             flattened vectors, element k at [k*BIT_WIDTH +: BIT_WIDTH]
//   i_signed             per-beat element interpretation (1 = two's complement)
//   i_first, i_last      accumulation delimiters for this beat
//   o_valid / i_ready    result handshake
//   o_product            accumulated dot product, two's complement, ACC_WIDTH bits
module vec_product_pipe #(
    parameter int BIT_WIDTH = 4,
    parameter int VEC_SIZE  = 64,
    parameter int ACC_WIDTH = BIT_WIDTH * 2 + $clog2(VEC_SIZE) + 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [BIT_WIDTH*VEC_SIZE-1:0] i_a,
    input  logic [BIT_WIDTH*VEC_SIZE-1:0] i_b,
    input  logic                          i_signed,
    input  logic                          i_first,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ACC_WIDTH-1:0]          o_product
);

    localparam int LEVELS = $clog2(VEC_SIZE);
    localparam int PW     = 2 * BIT_WIDTH + 1;   // product width
    localparam int TW     = PW + LEVELS;         // final tree-sum width

    // Sideband per stage: index 0 is the product stage, index LEVELS the tree root.
    logic [LEVELS:0]    vld_q;
    logic [LEVELS:0]    fst_q;
    logic [LEVELS:0]    lst_q;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] product_q, product_d;
    logic                 o_valid_q, o_valid_d;

    logic                 advance;

    // The whole pipe freezes only while a finished result is waiting downstream.
    assign advance = ~(o_valid_q & ~i_ready);
    assign o_ready = advance;

    // Each operand is widened by one bit (sign or zero) so that both signed
    // and unsigned products are exact in PW bits.
    function automatic logic [PW-1:0] mul_ext(input logic [BIT_WIDTH-1:0] a,
                                              input logic [BIT_WIDTH-1:0] b,
                                              input logic                 sgn);
        logic signed [BIT_WIDTH:0] ea;
        logic signed [BIT_WIDTH:0] eb;
        logic signed [PW-1:0]      p;
        ea = {sgn & a[BIT_WIDTH-1], a};
        eb = {sgn & b[BIT_WIDTH-1], b};
        p  = PW'(ea) * PW'(eb);
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Datapath: products and adder tree. Level l holds VEC_SIZE>>l values
    // of PW+l bits, stored as raw two's-complement bits.
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = VEC_SIZE >> l;
        localparam int W = PW + l;
        logic [W-1:0] sum_q [N];

        if (l == 0) begin : g_leaf
            // NOTE: datapath registers carry no reset; only the valid sideband
            // decides whether their contents mean anything, which keeps reset
            // fan-out off the wide tree.
            always_ff @(posedge i_clk) begin
                if (advance) begin
                    for (int k = 0; k < N; k++) begin
                        sum_q[k] <= mul_ext(i_a[k*BIT_WIDTH +: BIT_WIDTH],
                                            i_b[k*BIT_WIDTH +: BIT_WIDTH],
                                            i_signed);
                    end
                end
            end
        end else begin : g_add
            // Sign-extend both children by one bit before adding so the sum is exact.
            always_ff @(posedge i_clk) begin
                if (advance) begin
                    for (int j = 0; j < N; j++) begin
                        sum_q[j] <= {g_lvl[l-1].sum_q[2*j][W-2],   g_lvl[l-1].sum_q[2*j]} +
                                    {g_lvl[l-1].sum_q[2*j+1][W-2], g_lvl[l-1].sum_q[2*j+1]};
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sideband shift register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
            fst_q <= '0;
            lst_q <= '0;
        end else if (advance) begin
            vld_q <= {vld_q[LEVELS-1:0], i_valid};
            fst_q <= {fst_q[LEVELS-1:0], i_first};
            lst_q <= {lst_q[LEVELS-1:0], i_last};
        end
    end

    // ------------------------------------------------------------------
    // Accumulate / output stage
    // ------------------------------------------------------------------
    logic signed [TW-1:0]  tree_root;
    logic [ACC_WIDTH-1:0]  tree_sum;
    logic [ACC_WIDTH-1:0]  acc_next;

    assign tree_root = g_lvl[LEVELS].sum_q[0];
    assign tree_sum  = ACC_WIDTH'(tree_root);   // sign-extends
    assign acc_next  = fst_q[LEVELS] ? tree_sum : acc_q + tree_sum;  // wraps

    // NOTE: every variable gets its default at the top of the block; that is
    // what keeps this combinational block from inferring latches.
    always_comb begin
        acc_d     = acc_q;
        product_d = product_q;
        o_valid_d = o_valid_q;
        if (advance) begin
            o_valid_d = 1'b0;
            if (vld_q[LEVELS]) begin
                if (lst_q[LEVELS]) begin
                    product_d = acc_next;
                    o_valid_d = 1'b1;
                    acc_d     = '0;
                end else begin
                    acc_d     = acc_next;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q     <= '0;
            product_q <= '0;
            o_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            product_q <= product_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign o_valid   = o_valid_q;
    assign o_product = product_q;

endmodule

// File: tb/tb_vec_product_pipe.sv
// tb_vec_product_pipe
//   Self-checking bench for vec_product_pipe. A reference model computes each
//   beat's dot product from the elements with plain integer arithmetic and
//   queues the expected results; a negedge monitor consumes DUT results.
//   A second instance with a 16-bit accumulator covers wrap-around.
module tb_vec_product_pipe;

    localparam int BW  = 4;
    localparam int VS  = 64;
    localparam int AW  = BW * 2 + $clog2(VS) + 8;
    localparam int AW2 = 16;
    localparam logic [63:0] MASK1 = (64'd1 << AW) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             v1, v2;
    logic [BW*VS-1:0] a, b;
    logic             sgn, fst, lst;
    logic             rdy1;
    logic             o_ready1, o_valid1;
    logic [AW-1:0]    prod1;
    logic             o_ready2, o_valid2;
    logic [AW2-1:0]   prod2;

    vec_product_pipe #(.BIT_WIDTH(BW), .VEC_SIZE(VS)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(o_ready1),
        .i_a(a), .i_b(b), .i_signed(sgn), .i_first(fst), .i_last(lst),
        .o_valid(o_valid1), .i_ready(rdy1), .o_product(prod1)
    );

    vec_product_pipe #(.BIT_WIDTH(BW), .VEC_SIZE(VS), .ACC_WIDTH(AW2)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(o_ready2),
        .i_a(a), .i_b(b), .i_signed(sgn), .i_first(fst), .i_last(lst),
        .o_valid(o_valid2), .i_ready(1'b1), .o_product(prod2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint      m_acc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_log[$];
    int          stall_cycles = 0;

    function automatic longint beat_sum(input logic [BW*VS-1:0] x, input logic [BW*VS-1:0] y,
                                       input logic s);
        longint tot = 0;
        for (int k = 0; k < VS; k++) begin
            int ea, eb;
            ea = s ? int'($signed(x[k*BW +: BW])) : int'(x[k*BW +: BW]);
            eb = s ? int'($signed(y[k*BW +: BW])) : int'(y[k*BW +: BW]);
            tot += longint'(ea * eb);
        end
        return tot;
    endfunction

    function automatic logic [63:0] to_acc(input longint v);
        return 64'(v) & MASK1;
    endfunction

    function automatic logic [BW*VS-1:0] fill(input logic [BW-1:0] e);
        logic [BW*VS-1:0] r;
        for (int k = 0; k < VS; k++) r[k*BW +: BW] = e;
        return r;
    endfunction

    function automatic logic [BW*VS-1:0] rand_vec();
        logic [BW*VS-1:0] r;
        for (int k = 0; k < BW*VS/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic send(input logic [BW*VS-1:0] av, input logic [BW*VS-1:0] bv,
                        input logic s, input logic f, input logic l);
        logic   ok;
        int     t;
        longint bs;
        a = av; b = bv; sgn = s; fst = f; lst = l; v1 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            ok = o_ready1;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 100);
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            bs    = beat_sum(av, bv, s);
            m_acc = f ? bs : m_acc + bs;
            if (l) begin
                exp_q.push_back(to_acc(m_acc));
                m_acc = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        v1 = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        v1 = 1'b0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        idle(12);   // let any trailing non-last beats leave the pipe
    endtask

    task automatic do_reset();
        v1 = 1'b0; v2 = 1'b0; rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        m_acc = 0;
        rst   = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid1), 64'd0);
        check("rst_o_product", 64'(prod1), 64'd0);
        check("rst_o_ready", 64'(o_ready1), 64'd1);
        check("rst_o_valid16", 64'(o_valid2), 64'd0);
        check("rst_o_product16", 64'(prod2), 64'd0);
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_prod  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(o_valid1), 64'd1);
                check("hold_product", 64'(prod1), 64'(prev_prod));
            end
            if (o_valid1 && !rdy1) begin
                stall_cycles++;
                check("o_ready_stalled", 64'(o_ready1), 64'd0);
            end else begin
                check("o_ready_free", 64'(o_ready1), 64'd1);
            end
            if (o_valid1 && rdy1) begin
                got_log.push_back(64'(prod1));
                if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
                else                   check("result", 64'(prod1), exp_q.pop_front());
            end
            prev_stall = o_valid1 && !rdy1;
            prev_prod  = prod1;
        end
    end

    // ---------------- test sequence ----------------
    logic             rand_on;
    logic [BW*VS-1:0] va;
    int               base, lat;
    longint           wrap_exp;

    initial begin
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; rdy1 = 1'b1;
        a = '0; b = '0; sgn = 1'b0; fst = 1'b0; lst = 1'b0;
        rand_on = 1'b0;

        // 1: a=1, b=-1 signed, single beat; latency 8
        do_reset();
        base = got_log.size();
        send(fill(4'h1), fill(4'hF), 1'b1, 1'b1, 1'b1);
        v1  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_valid1 && lat < 30);
        check("t1_latency", 64'(lat), 64'd8);
        drain();
        check("t1_count", 64'(got_log.size() - base), 64'd1);
        if (got_log.size() > base) check("t1_product", got_log[base], to_acc(-64));

        // 2: unsigned 15*15, then the same bits signed
        base = got_log.size();
        send(fill(4'hF), fill(4'hF), 1'b0, 1'b1, 1'b1);
        send(fill(4'hF), fill(4'hF), 1'b1, 1'b1, 1'b1);
        drain();
        check("t2_count", 64'(got_log.size() - base), 64'd2);
        if (got_log.size() >= base + 2) begin
            check("t2_unsigned", got_log[base], 64'd14400);
            check("t2_signed", got_log[base+1], 64'd64);
        end

        // 3: three beats of +100 each
        va = '0;
        for (int k = 0; k < 25; k++) va[k*BW +: BW] = 4'h2;
        base = got_log.size();
        send(va, fill(4'h2), 1'b1, 1'b1, 1'b0);
        send(va, fill(4'h2), 1'b1, 1'b0, 1'b0);
        send(va, fill(4'h2), 1'b1, 1'b0, 1'b1);
        drain();
        check("t3_count", 64'(got_log.size() - base), 64'd1);
        if (got_log.size() > base) check("t3_product", got_log[base], 64'd300);

        // 4: 20 single-beat vectors with a 5-cycle downstream stall
        base = got_log.size();
        stall_cycles = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send(rand_vec(), rand_vec(), 1'($urandom), 1'b1, 1'b1);
                v1 = 1'b0;
            end
            begin
                repeat (12) begin
                    @(posedge clk);
                    #1;
                end
                rdy1 = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                rdy1 = 1'b1;
            end
        join
        drain();
        check("t4_count", 64'(got_log.size() - base), 64'd20);
        check("t4_stall_seen", 64'(stall_cycles >= 5), 64'd1);

        // 5: reset with three beats in flight, then a=b=2
        send(rand_vec(), rand_vec(), 1'b1, 1'b1, 1'b0);
        send(rand_vec(), rand_vec(), 1'b0, 1'b0, 1'b0);
        send(rand_vec(), rand_vec(), 1'b1, 1'b0, 1'b1);
        do_reset();
        base = got_log.size();
        send(fill(4'h2), fill(4'h2), 1'b1, 1'b1, 1'b1);
        drain();
        check("t5_count", 64'(got_log.size() - base), 64'd1);
        if (got_log.size() > base) check("t5_product", got_log[base], 64'd256);

        // 6: 16-bit accumulator wraps over 300 beats of (-8)*(-8)
        a = fill(4'h8); b = fill(4'h8); sgn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            fst = (i == 0); lst = (i == 299); v2 = 1'b1;
            @(posedge clk);
            #1;
        end
        v2  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_valid2 && lat < 30);
        wrap_exp = (300 * 4096) % 65536;
        check("t6_valid", 64'(o_valid2), 64'd1);
        check("t6_product", 64'(prod2), 64'(wrap_exp));
        check("t6_signed", 64'($signed(prod2)), 64'(-16384));

        // 7: random beats, random delimiters, random backpressure
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 150; i++)
                    send(rand_vec(), rand_vec(), 1'($urandom),
                         ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
                send(rand_vec(), rand_vec(), 1'($urandom), 1'b0, 1'b1);
                v1 = 1'b0;
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    rdy1 = ($urandom_range(0, 3) != 0);
                end
                rdy1 = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
